// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap CSRs, external interrupt qualification and post-redirect pipeline flush
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   ext_irq_in                    raw external interrupt level (asynchronous)
//   csr_we/csr_addr/csr_wdata     CSR write port; csr_rdata is a combinational read of csr_addr
//   trap_taken/trap_return        redirect from a trap or mret; trap_return marks an mret
//   trap_src/trap_pc              trap cause code (5'h1F = none) and pc of the trapping instruction
//   branch_taken                  taken branch/jump redirect
//   external_int                  qualified interrupt request to the jump unit
//   mtvec_rdata/mepc_rdata        direct register views of mtvec and mepc
//   pipe_flush                    flush of younger stages, held FLUSH_CYCLES cycles after a redirect
module trap_ctrl #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_MTVEC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ext_irq_in,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        trap_taken,
  input  logic        trap_return,
  input  logic [4:0]  trap_src,
  input  logic [31:0] trap_pc,
  input  logic        branch_taken,
  output logic        external_int,
  output logic [31:0] mtvec_rdata,
  output logic [31:0] mepc_rdata,
  output logic        pipe_flush
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  logic [0:0]  state;
  logic [3:0]  cnt;
  logic        irq_s1, meip, mie_b, mpie, meie;
  logic [31:2] mtvec, mepc;
  logic [31:0] mcause;
  logic        idle, trap, mret, redirect;
  assign idle     = state == IDLE;
  // redirects seen during FLUSH belong to squashed instructions and are dropped
  assign trap     = idle & trap_taken & ~trap_return & (trap_src != 5'h1F);
  assign mret     = idle & trap_taken & trap_return & ~trap;
  assign redirect = idle & (trap_taken | branch_taken);
  assign external_int = meip & meie & mie_b & idle;
  assign mtvec_rdata  = {mtvec, 2'b00};
  assign mepc_rdata   = {mepc, 2'b00};
  assign pipe_flush   = state == FLUSH;
  always_comb
    csr_rdata = csr_addr == 12'h300 ? {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie_b, 3'b0} :
                csr_addr == 12'h304 ? {20'b0, meie, 11'b0} :
                csr_addr == 12'h305 ? {mtvec, 2'b00} :
                csr_addr == 12'h341 ? {mepc, 2'b00} :
                csr_addr == 12'h342 ? mcause :
                csr_addr == 12'h344 ? {20'b0, meip, 11'b0} : 32'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      irq_s1 <= 1'b0;
      meip   <= 1'b0;
      mie_b  <= 1'b0;
      mpie   <= 1'b0;
      meie   <= 1'b0;
      mtvec  <= RESET_MTVEC[31:2];
      mepc   <= '0;
      mcause <= '0;
      state  <= IDLE;
      cnt    <= '0;
    end else begin
      irq_s1 <= ext_irq_in;
      meip   <= irq_s1;
      if (csr_we && csr_addr == 12'h304) meie <= csr_wdata[11];
      if (csr_we && csr_addr == 12'h305) mtvec <= csr_wdata[31:2];
      // trap/mret state updates take priority over a CSR write in the same cycle
      if (trap) begin
        mepc   <= trap_pc[31:2];
        mcause <= {trap_src[4], 27'b0, trap_src[3:0]};
        mpie   <= mie_b;
        mie_b  <= 1'b0;
      end else if (mret) begin
        mie_b <= mpie;
        mpie  <= 1'b1;
      end else if (csr_we) begin
        if (csr_addr == 12'h300) begin
          mie_b <= csr_wdata[3];
          mpie  <= csr_wdata[7];
        end
        if (csr_addr == 12'h341) mepc <= csr_wdata[31:2];
        if (csr_addr == 12'h342) mcause <= csr_wdata;
      end
      if (redirect) begin
        state <= FLUSH;
        cnt   <= 4'(FLUSH_CYCLES - 1);
      end else if (!idle) begin
        state <= cnt == 4'd0 ? IDLE : FLUSH;
        cnt   <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: scoreboard bench for trap_ctrl with directed vectors
module tb_trap_ctrl;
  localparam logic [31:0] RST_TVEC = 32'h0000_0103;
  logic        clk = 0, rst_n = 0, ext_irq_in = 0, csr_we = 0;
  logic [11:0] csr_addr = 0;
  logic [31:0] csr_wdata = 0, csr_rdata, trap_pc = 0, mtvec_rdata, mepc_rdata;
  logic        trap_taken = 0, trap_return = 0, branch_taken = 0, external_int, pipe_flush;
  logic [4:0]  trap_src = 5'h1F;
  int          checks = 0, errors = 0;
  typedef struct { int k; logic [31:0] v; string nm; } exp_t;
  exp_t q[$];
  trap_ctrl #(.FLUSH_CYCLES(2), .RESET_MTVEC(RST_TVEC)) dut (
    .clk(clk), .rst_n(rst_n), .ext_irq_in(ext_irq_in), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .trap_taken(trap_taken), .trap_return(trap_return),
    .trap_src(trap_src), .trap_pc(trap_pc), .branch_taken(branch_taken), .external_int(external_int),
    .mtvec_rdata(mtvec_rdata), .mepc_rdata(mepc_rdata), .pipe_flush(pipe_flush)
  );
  always #5 clk = ~clk;
  // k: 0 csr_rdata, 1 pipe_flush, 2 external_int, 3 mtvec_rdata, 4 mepc_rdata
  function automatic logic [31:0] sel(int k);
    return k == 0 ? csr_rdata : k == 1 ? {31'b0, pipe_flush} : k == 2 ? {31'b0, external_int} :
           k == 3 ? mtvec_rdata : mepc_rdata;
  endfunction
  initial forever begin
    @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = sel(e.k);
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.nm, a, e.v);
      end
    end
  end
  task automatic expect_v(int k, logic [31:0] v, string nm);
    exp_t e;
    e.k = k; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(logic [11:0] a, logic [31:0] v, string nm);
    csr_addr = a;
    expect_v(0, v, nm);
    tick();
  endtask
  task automatic wr(logic [11:0] a, logic [31:0] d);
    csr_we = 1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 0;
  endtask
  initial begin
    tick();
    expect_v(1, 0, "rst_flush");
    expect_v(2, 0, "rst_ext_int");
    tick();
    rst_n = 1;
    rd(12'h300, 32'h1800, "rst_mstatus");
    rd(12'h304, 32'h0, "rst_mie");
    rd(12'h305, 32'h100, "rst_mtvec");
    rd(12'h341, 32'h0, "rst_mepc");
    rd(12'h342, 32'h0, "rst_mcause");
    rd(12'h344, 32'h0, "rst_mip");
    rd(12'h123, 32'h0, "unmapped");
    wr(12'h305, 32'h0000_1003);
    wr(12'h304, 32'h800);
    wr(12'h300, 32'h8);
    wr(12'h123, 32'hFFFF_FFFF);
    rd(12'h305, 32'h1000, "mtvec_wr");
    rd(12'h300, 32'h1808, "mstatus_wr");
    rd(12'h123, 32'h0, "unmapped_wr");
    ext_irq_in = 1;
    expect_v(2, 0, "irq_not_yet");
    tick(); tick(); tick();
    expect_v(2, 1, "irq_ext_int");
    rd(12'h344, 32'h800, "mip_meip");
    trap_taken = 1; trap_src = 5'h02; trap_pc = 32'h104;
    tick();
    trap_taken = 0; trap_src = 5'h1F;
    expect_v(4, 32'h104, "trap_mepc");
    expect_v(1, 1, "trap_flush1");
    expect_v(2, 0, "trap_int1");
    rd(12'h342, 32'h2, "trap_mcause");
    expect_v(1, 1, "trap_flush2");
    expect_v(2, 0, "trap_int2");
    rd(12'h300, 32'h1880, "trap_mstatus");
    expect_v(1, 0, "trap_flush_end");
    trap_taken = 1; trap_return = 1;
    tick();
    trap_taken = 0; trap_return = 0;
    expect_v(1, 1, "mret_flush1");
    expect_v(2, 0, "mret_int1");
    rd(12'h300, 32'h1888, "mret_mstatus");
    expect_v(1, 1, "mret_flush2");
    tick();
    expect_v(1, 0, "mret_flush_end");
    expect_v(2, 1, "mret_int_back");
    trap_taken = 1; trap_src = 5'h13; trap_pc = 32'h207;
    wr(12'h341, 32'hDEAD_0000);
    trap_taken = 0; trap_src = 5'h1F;
    expect_v(4, 32'h204, "trap_vs_mepc_wr");
    rd(12'h342, 32'h8000_0003, "mcause_int_bit");
    tick();
    trap_taken = 1; trap_src = 5'h05; trap_pc = 32'h300;
    wr(12'h305, 32'h2000);
    trap_taken = 0; trap_src = 5'h1F;
    expect_v(3, 32'h2000, "trap_mtvec_wr");
    expect_v(4, 32'h300, "trap2_mepc");
    rd(12'h300, 32'h1800, "trap2_mstatus");
    tick();
    expect_v(1, 0, "pre_branch_idle");
    branch_taken = 1;
    tick();
    branch_taken = 0;
    trap_taken = 1; trap_src = 5'h07; trap_pc = 32'h500;
    expect_v(1, 1, "br_flush1");
    tick();
    trap_taken = 0; trap_src = 5'h1F;
    expect_v(1, 1, "br_flush2");
    expect_v(4, 32'h300, "br_mepc_kept");
    rd(12'h342, 32'h5, "br_mcause_kept");
    expect_v(1, 0, "br_flush_end");
    tick();
    branch_taken = 1;
    tick();
    branch_taken = 0;
    expect_v(1, 1, "pre_rst_flush");
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    expect_v(1, 0, "async_rst_flush");
    expect_v(3, 32'h100, "async_rst_mtvec");
    tick();
    rst_n = 1;
    expect_v(1, 0, "post_rst_idle");
    tick();
    branch_taken = 1;
    tick();
    branch_taken = 0;
    expect_v(1, 1, "post_rst_redirect");
    tick(); tick();
    expect_v(1, 0, "post_rst_done");
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
